// File: rtl/vend_dispense_ctrl_if.sv
// vend_dispense_ctrl_if
//   Request/acknowledge handshake to the 1-cent change hopper.
//   coin_eject : request, held by the controller until the hopper acks
//   coin_done  : 1-cycle ack from the hopper, one coin ejected
//   modport master : controller side (drives coin_eject)
//   modport slave  : hopper side (drives coin_done)
interface vend_dispense_ctrl_if;
   logic coin_eject;
   logic coin_done;

   modport master (output coin_eject, input coin_done);
   modport slave  (input coin_eject, output coin_done);
endinterface

// File: rtl/vend_dispense_ctrl.sv
// vend_dispense_ctrl
//   Downstream of the vending FSM. Queues vend requests (d) and change owed
//   (r), then drives the product motor and a 1-cent change hopper.
//   Vends always take priority over change.
//
// Ports
//   clk        : clock, all state on rising edge
//   reset      : synchronous, active-high; clears all state and outputs
//   vend_req   : vending FSM d, level; rising edge = one vend
//   change_amt : vending FSM r; nonzero = one change event of that many cents
//   hopper     : hopper handshake (coin_eject out, coin_done in)
//   motor_on   : product motor drive
//   busy       : work pending or in progress
//   ovf        : sticky, a pending counter saturated
//   fault      : sticky, hopper timeout
//
// Configuration
//   VEND_HOPPER_TIMEOUT_EN : builds the hopper watchdog (tcnt) and the FAULT
//                            path; undefined ties fault to 0.
module vend_dispense_ctrl #(
   parameter int unsigned MOTOR_CYCLES = 8,
   parameter int unsigned CHG_W        = 5,
   parameter int unsigned TIMEOUT      = 255
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        vend_req,
   input  logic [2:0]                  change_amt,
   vend_dispense_ctrl_if.master        hopper,
   output logic                        motor_on,
   output logic                        busy,
   output logic                        ovf,
   output logic                        fault
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_VEND,
      S_CHG_REQ,
      S_GAP,
      S_FAULT
   } state_e;

   localparam int unsigned MCNT_W = (MOTOR_CYCLES > 1) ? $clog2(MOTOR_CYCLES) : 1;
   localparam logic [MCNT_W-1:0] MCNT_LAST = MCNT_W'(MOTOR_CYCLES - 1);
   // Wide enough for max pending + max event without wrap.
   localparam int unsigned SUM_W = CHG_W + 4;
   localparam logic [CHG_W-1:0] CHG_MAX = '1;

   if (MOTOR_CYCLES < 1 || TIMEOUT < 1) begin : g_bad_param
      $error("vend_dispense_ctrl: MOTOR_CYCLES and TIMEOUT must be >= 1");
   end

   state_e            state_q, state_d;
   logic              vend_q;
   logic [1:0]        vend_pend_q, vend_pend_d;
   logic [CHG_W-1:0]  chg_pend_q, chg_pend_d;
   logic [MCNT_W-1:0] mcnt_q, mcnt_d;
   logic              ovf_q, ovf_d;

`ifdef VEND_HOPPER_TIMEOUT_EN
   localparam int unsigned TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);
   logic [TCNT_W-1:0] tcnt_q, tcnt_d;
`endif

   logic             vend_ev;
   logic             vend_take;
   logic             coin_take;
   logic [2:0]       vend_sum;
   logic [SUM_W-1:0] chg_sum;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         vend_q      <= 1'b0;
         vend_pend_q <= '0;
         chg_pend_q  <= '0;
         mcnt_q      <= '0;
         ovf_q       <= 1'b0;
`ifdef VEND_HOPPER_TIMEOUT_EN
         tcnt_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         vend_q      <= vend_req;
         vend_pend_q <= vend_pend_d;
         chg_pend_q  <= chg_pend_d;
         mcnt_q      <= mcnt_d;
         ovf_q       <= ovf_d;
`ifdef VEND_HOPPER_TIMEOUT_EN
         tcnt_q      <= tcnt_d;
`endif
      end
   end

   // Next state
   always_comb begin
      state_d   = state_q;
      mcnt_d    = mcnt_q;
      vend_take = 1'b0;
      coin_take = 1'b0;
`ifdef VEND_HOPPER_TIMEOUT_EN
      tcnt_d    = tcnt_q;
`endif
      case (state_q)
         S_IDLE, S_GAP: begin
            if (vend_pend_q != '0) begin
               state_d   = S_VEND;
               mcnt_d    = '0;
               vend_take = 1'b1;
            end else if (chg_pend_q != '0) begin
               state_d = S_CHG_REQ;
`ifdef VEND_HOPPER_TIMEOUT_EN
               tcnt_d  = '0;
`endif
            end else begin
               state_d = S_IDLE;
            end
         end
         S_VEND: begin
            if (mcnt_q == MCNT_LAST) state_d = S_GAP;
            else                     mcnt_d  = mcnt_q + 1'b1;
         end
         S_CHG_REQ: begin
            if (hopper.coin_done) begin
               coin_take = 1'b1;
               state_d   = S_GAP;
            end
`ifdef VEND_HOPPER_TIMEOUT_EN
            else if (tcnt_q == TCNT_LAST) state_d = S_FAULT;
            else                          tcnt_d  = tcnt_q + 1'b1;
`endif
         end
         S_FAULT: state_d = S_FAULT;
         default: state_d = S_IDLE;
      endcase
   end

   // Pending counters: net add/decrement first, then saturate.
   always_comb begin
      vend_ev  = vend_req & ~vend_q;
      vend_sum = {1'b0, vend_pend_q} + {2'b00, vend_ev} - {2'b00, vend_take};
      chg_sum  = SUM_W'(chg_pend_q) + SUM_W'(change_amt) - SUM_W'(coin_take);
      ovf_d    = ovf_q;
      if (vend_sum > 3'd3) begin
         vend_pend_d = 2'd3;
         ovf_d       = 1'b1;
      end else begin
         vend_pend_d = vend_sum[1:0];
      end
      if (chg_sum > SUM_W'(CHG_MAX)) begin
         chg_pend_d = CHG_MAX;
         ovf_d      = 1'b1;
      end else begin
         chg_pend_d = chg_sum[CHG_W-1:0];
      end
   end

   // Outputs
   always_comb begin
      motor_on          = (state_q == S_VEND);
      hopper.coin_eject = (state_q == S_CHG_REQ);
      busy              = (state_q != S_IDLE) | (vend_pend_q != '0) | (chg_pend_q != '0);
      ovf               = ovf_q;
`ifdef VEND_HOPPER_TIMEOUT_EN
      fault             = (state_q == S_FAULT);
`else
      fault             = 1'b0;
`endif
   end

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// tb_vend_dispense_ctrl
//   Scoreboard bench for vend_dispense_ctrl: each motor burst and coin
//   request pulse expected from a stimulus is queued with its start edge and
//   length, then matched when the pulse ends.
module tb_vend_dispense_ctrl;
   localparam int unsigned MOTOR_CYCLES = 8;
   localparam int unsigned CHG_W        = 5;
   localparam int unsigned TIMEOUT      = 255;
   localparam int EV_MOTOR = 0;
   localparam int EV_COIN  = 1;

   typedef struct {
      int kind;
      int start;
      int len;
   } ev_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       vend_req = 1'b0;
   logic [2:0] change_amt = '0;
   logic       motor_on, busy, ovf, fault;
   logic       ack_en = 1'b1;
   logic       hop_done_q = 1'b0;

   int   checks = 0;
   int   failures = 0;
   int   edge_n = 0;
   ev_t  sb_q[$];

   vend_dispense_ctrl_if hop_if ();
   assign hop_if.coin_done = hop_done_q;

   vend_dispense_ctrl #(
      .MOTOR_CYCLES(MOTOR_CYCLES),
      .CHG_W       (CHG_W),
      .TIMEOUT     (TIMEOUT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .vend_req  (vend_req),
      .change_amt(change_amt),
      .hopper    (hop_if.master),
      .motor_on  (motor_on),
      .busy      (busy),
      .ovf       (ovf),
      .fault     (fault)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edge_n = edge_n + 1;

   // Hopper model: acks one cycle after it sees a request.
   always @(posedge clk) begin
      if (reset) hop_done_q <= 1'b0;
      else       hop_done_q <= ack_en & hop_if.coin_eject & ~hop_done_q;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic push(input int kind, input int start, input int len);
      ev_t e;
      e.kind  = kind;
      e.start = start;
      e.len   = len;
      sb_q.push_back(e);
   endtask

   task automatic sb_pop(input int kind, input int start, input int len);
      ev_t e;
      if (sb_q.size() == 0) begin
         chk($sformatf("sb_unexpected_kind%0d_at%0d", kind, start), sb_q.size(), 1);
         return;
      end
      e = sb_q.pop_front();
      chk("sb_kind", kind, e.kind);
      chk($sformatf("sb_start_kind%0d", kind), start, e.start);
      chk($sformatf("sb_len_kind%0d", kind), len, e.len);
   endtask

   // Pulse monitor
   logic motor_prev = 1'b0, coin_prev = 1'b0;
   int   motor_start = 0, coin_start = 0;
   always @(negedge clk) begin
      if (reset) begin
         motor_prev = 1'b0;
         coin_prev  = 1'b0;
      end else begin
         if (motor_on && !motor_prev) motor_start = edge_n;
         if (!motor_on && motor_prev) sb_pop(EV_MOTOR, motor_start, edge_n - motor_start);
         if (hop_if.coin_eject && !coin_prev) coin_start = edge_n;
         if (!hop_if.coin_eject && coin_prev) sb_pop(EV_COIN, coin_start, edge_n - coin_start);
         motor_prev = motor_on;
         coin_prev  = hop_if.coin_eject;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_to(input int n);
      while (edge_n < n) tick();
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n = 0;
      while (busy && n < budget) begin
         tick();
         n++;
      end
      chk({tag, "_busy_end"}, busy, 0);
      tick();
      chk({tag, "_sb_empty"}, sb_q.size(), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int e;
      int vpat[9];
      int cpat[9];
      vpat = '{1, 0, 1, 0, 1, 0, 1, 0, 1};
      cpat = '{7, 7, 7, 7, 7, 5, 0, 0, 0};

      repeat (3) tick();
      chk("rst_motor", motor_on, 0);
      chk("rst_eject", hop_if.coin_eject, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_fault", fault, 0);
      reset = 1'b0;
      tick();

      // Held vend level: one burst, busy drops after the gap
      e = edge_n;
      push(EV_MOTOR, e + 2, MOTOR_CYCLES);
      vend_req = 1'b1;
      repeat (4) tick();
      vend_req = 1'b0;
      tick_to(e + 2 + MOTOR_CYCLES);
      chk("t1_gap_busy", busy, 1);
      chk("t1_gap_motor", motor_on, 0);
      tick();
      chk("t1_idle_busy", busy, 0);
      tick();
      chk("t1_sb_empty", sb_q.size(), 0);

      // Three coins, period 3
      e = edge_n;
      for (int i = 0; i < 3; i++) push(EV_COIN, e + 2 + 3 * i, 2);
      change_amt = 3'd3;
      tick();
      change_amt = '0;
      chk("t2_chg_cap", dut.chg_pend_q, 3);
      wait_idle("t2", 40);
      chk("t2_chg_zero", dut.chg_pend_q, 0);

      // Vend preempts between coins
      e = edge_n;
      push(EV_COIN, e + 2, 2);
      push(EV_MOTOR, e + 5, MOTOR_CYCLES);
      for (int i = 0; i < 3; i++) push(EV_COIN, e + 14 + 3 * i, 2);
      change_amt = 3'd4;
      tick();
      change_amt = '0;
      tick();
      vend_req = 1'b1;
      repeat (2) tick();
      vend_req = 1'b0;
      wait_idle("t3", 60);

      // Saturation of both pending counters
      e = edge_n;
      for (int i = 0; i < 4; i++) push(EV_MOTOR, e + 2 + 9 * i, MOTOR_CYCLES);
      for (int i = 0; i < 31; i++) push(EV_COIN, e + 38 + 3 * i, 2);
      for (int j = 0; j < 9; j++) begin
         vend_req   = vpat[j][0];
         change_amt = 3'(cpat[j]);
         tick();
         if (j == 3) begin
            chk("t4_pre_ovf", ovf, 0);
            chk("t4_pre_chg", dut.chg_pend_q, 28);
         end
      end
      vend_req   = 1'b0;
      change_amt = '0;
      chk("t4_vend_sat", dut.vend_pend_q, 3);
      chk("t4_chg_sat", dut.chg_pend_q, 31);
      chk("t4_ovf", ovf, 1);
      wait_idle("t4", 200);
      chk("t4_ovf_sticky", ovf, 1);
      reset = 1'b1;
      tick();
      chk("t4_ovf_cleared", ovf, 0);
      reset = 1'b0;
      tick();

      // Hopper never acks
      ack_en = 1'b0;
      e = edge_n;
      change_amt = 3'd1;
      tick();
      change_amt = '0;
`ifdef VEND_HOPPER_TIMEOUT_EN
      push(EV_COIN, e + 2, TIMEOUT);
      tick_to(e + 2 + TIMEOUT + 2);
      chk("t5_fault", fault, 1);
      chk("t5_eject_off", hop_if.coin_eject, 0);
      vend_req   = 1'b1;
      change_amt = 3'd2;
      ack_en     = 1'b1;
      tick();
      vend_req   = 1'b0;
      change_amt = '0;
      repeat (20) tick();
      chk("t5_fault_motor", motor_on, 0);
      chk("t5_fault_vend_acc", dut.vend_pend_q, 1);
      chk("t5_fault_chg_acc", dut.chg_pend_q, 3);
      chk("t5_fault_hold", fault, 1);
`else
      tick_to(e + 2 + 300);
      chk("t5_eject_held", hop_if.coin_eject, 1);
      chk("t5_no_fault", fault, 0);
      chk("t5_busy", busy, 1);
`endif
      reset = 1'b1;
      tick();
      chk("t5_rst_eject", hop_if.coin_eject, 0);
      chk("t5_rst_fault", fault, 0);
      chk("t5_rst_busy", busy, 0);
      reset  = 1'b0;
      ack_en = 1'b1;
      tick();

      // Reset mid-burst discards pending vend
      e = edge_n;
      vend_req = 1'b1;
      tick();
      vend_req = 1'b0;
      tick();
      vend_req = 1'b1;
      tick();
      tick();
      chk("t6_motor_on", motor_on, 1);
      chk("t6_vend_pending", dut.vend_pend_q, 1);
      reset    = 1'b1;
      vend_req = 1'b0;
      tick();
      chk("t6_rst_motor", motor_on, 0);
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_pend", dut.vend_pend_q, 0);
      reset = 1'b0;
      repeat (20) tick();
      chk("t6_no_restart", motor_on, 0);
      chk("t6_idle", busy, 0);
      chk("end_sb_empty", sb_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
